// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit, fixed 32-iteration schedule
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic        result_write,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] mag_a_q, mag_b_q;
  logic [31:0] hi_q, lo_q;
  logic        neg_q, neg_rem_q, spec_q;
  logic [31:0] spec_val_q;
  logic        busy_q, done_q;
  logic [31:0] result_q;
  logic [4:0]  rd_q;

  // hi/lo are shared: multiply keeps {accumulator, multiplier}, divide keeps {remainder, dividend/quotient}
  logic [32:0] mul_sum, div_shift, div_trial;
  logic [31:0] hi_d, lo_d;
  logic [63:0] prod, prod_s;
  logic [31:0] quo_s, rem_s, final_val;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mag_a_q : 32'd0)};
    div_shift = {hi_q, lo_q[31]};
    div_trial = div_shift - {1'b0, mag_b_q};
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (op_q[2]) begin
      if (!div_trial[32]) begin
        hi_d = div_trial[31:0];
        lo_d = {lo_q[30:0], 1'b1};
      end else begin
        hi_d = div_shift[31:0];
        lo_d = {lo_q[30:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[32:1];
      lo_d = {mul_sum[0], lo_q[31:1]};
    end
    prod   = {hi_d, lo_d};
    prod_s = neg_q ? (64'd0 - prod) : prod;
    quo_s  = neg_q ? (32'd0 - lo_d) : lo_d;
    rem_s  = neg_rem_q ? (32'd0 - hi_d) : hi_d;
    if (spec_q)
      final_val = spec_val_q;
    else if (op_q[2])
      final_val = op_q[1] ? rem_s : quo_s;
    else
      final_val = (op_q == 3'b000) ? prod_s[31:0] : prod_s[63:32];
  end

  logic        a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [31:0] mag_a_d, mag_b_d, spec_val_d;

  always_comb begin
    a_sgn      = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn      = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg      = a_sgn && rs1_data[31];
    b_neg      = b_sgn && rs2_data[31];
    mag_a_d    = a_neg ? (32'd0 - rs1_data) : rs1_data;
    mag_b_d    = b_neg ? (32'd0 - rs2_data) : rs2_data;
    div_zero   = funct3[2] && (rs2_data == 32'd0);
    div_ovf    = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                 (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    spec_val_d = div_zero ? (funct3[1] ? rs1_data : 32'hFFFF_FFFF)
                          : (funct3[1] ? 32'd0 : 32'h8000_0000);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      op_q       <= 3'd0;
      mag_a_q    <= 32'd0;
      mag_b_q    <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 32'd0;
      rd_q       <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_CALC;
            cnt_q      <= 5'd0;
            op_q       <= funct3;
            rd_q       <= rd_in;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            hi_q       <= 32'd0;
            lo_q       <= funct3[2] ? mag_a_d : mag_b_d;
            neg_q      <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            spec_q     <= div_zero || div_ovf;
            spec_val_q <= spec_val_d;
            busy_q     <= 1'b1;
          end
        end
        S_CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q <= final_val;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result_write = done_q;
  assign result       = result_q;
  assign rd_out       = rd_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done, result_write;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .result_write(result_write),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    case (f)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int edges;
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
    funct3 = 3'($urandom);
    chk({nm, "_busy"}, busy, 1);
    edges = 0;
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk({nm, "_latency"}, edges, 32);
    chk({nm, "_result"}, result, exp);
    chk({nm, "_rd"}, rd_out, rd);
    chk({nm, "_write"}, result_write, 1);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, {done, result_write, busy}, 0);
    chk({nm, "_held"}, result, exp);
  endtask

  logic [2:0]  sf[102];
  logic [31:0] sa_v[102], sb_v[102];

  initial begin
    reset = 1'b1; start = 1'b0; funct3 = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0; rd_in = 5'd0;
    #1;
    chk("reset_outputs", {busy, done, result_write, result, rd_out}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    tbl[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    tbl[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000};
    tbl[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF};
    tbl[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE};
    tbl[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD};
    tbl[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF};
    tbl[6]  = '{3'b101, 32'd100,       32'd7,         5'd7,  32'd14};
    tbl[7]  = '{3'b111, 32'd100,       32'd7,         5'd8,  32'd2};
    tbl[8]  = '{3'b100, 32'h1234_5678, 32'd0,         5'd9,  32'hFFFF_FFFF};
    tbl[9]  = '{3'b111, 32'h1234_5678, 32'd0,         5'd10, 32'h1234_5678};
    tbl[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
    tbl[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000};

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f = 3'($urandom_range(0, 7)); a = pick(); b = pick(); rd = 5'($urandom);
      run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, rd, model(f, a, b));
    end

    begin
      int acc, ndone;
      acc = 0; ndone = 0;
      for (int k = 0; k < 102; k++) begin
        @(negedge clk);
        sf[k] = 3'($urandom_range(0, 7)); sa_v[k] = pick(); sb_v[k] = pick();
        start = 1'b1; funct3 = sf[k]; rs1_data = sa_v[k]; rs2_data = sb_v[k]; rd_in = 5'(k);
        @(posedge clk); #1;
        if (k >= acc && k <= acc + 32) chk($sformatf("stream_busy_e%0d", k), busy, 1);
        if (done) begin
          chk($sformatf("stream_latency_e%0d", k), k, acc + 32);
          chk($sformatf("stream_result_e%0d", k), result, model(sf[acc], sa_v[acc], sb_v[acc]));
          chk($sformatf("stream_rd_e%0d", k), rd_out, 5'(acc));
          ndone++;
          acc = k + 2;
        end
      end
      @(negedge clk); start = 1'b0;
      chk("stream_count", ndone, 3);
    end

    run_op("pre_reset_mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);

    begin
      int writes;
      @(negedge clk);
      start = 1'b1; funct3 = 3'b101; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd9;
      @(posedge clk); #1; start = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      chk("async_reset_outputs", {busy, done, result_write, result, rd_out}, 0);
      writes = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (result_write) writes++;
        if (k == 1) begin
          @(negedge clk); reset = 1'b0;
        end
      end
      chk("reset_no_write", writes, 0);
    end

    run_op("post_reset_mul", 3'b000, 32'd3, 32'd4, 5'd12, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit for the core's execute stage. Consumes the two operand values read from the register file (rs1/rs2 data), computes one of the eight M-extension operations over a fixed 32-iteration schedule, and returns a 32-bit result with a one-cycle write strobe and destination index. The register file's write port takes these as write_data/RegWrite/write_reg. The control path stalls while `busy` is high.

## Interface
- Parameters: none (XLEN fixed at 32).
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request; sampled only in IDLE
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_data  input  32  operand A (dividend / multiplicand)
- rs2_data  input  32  operand B (divisor / multiplier)
- rd_in  input  5  destination register index
- busy  output  1  high from the cycle after start acceptance through the DONE cycle
- done  output  1  one-cycle pulse; result valid
- result_write  output  1  equals done; drives register-file write enable
- result  output  32  final value; held from DONE until next acceptance
- rd_out  output  5  captured rd_in; held with result

## Operation
- States: IDLE, CALC, DONE.
- IDLE: start=1 at edge E0 captures funct3, rd_in, operand magnitudes and sign flags. Sets iteration counter to 0 and goes to CALC. start=0 holds IDLE.
- Signedness: MULH/DIV/REM treat both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. MUL, MULHU, DIVU and REMU are unsigned (MUL low word is sign-independent).
- Magnitude of -2^31 is 0x8000_0000 as an unsigned 32-bit value.
- Multiply: radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle. The product is negated (64-bit two's complement) when the operand signs differ. MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide: radix-2 restoring division on magnitudes, one quotient bit per cycle, 33-bit partial remainder.
- Sign rules for divide: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
- Special cases are detected at E0. They follow the same fixed schedule, and their result is substituted at finalisation:
  - Divisor 0: DIV/DIVU give 0xFFFF_FFFF; REM/REMU give rs1_data.
  - Signed overflow (rs1=0x8000_0000, rs2=0xFFFF_FFFF): DIV gives 0x8000_0000; REM gives 0.
- CALC: one iteration per edge; counter increments. At the edge where counter==31, the final iteration, sign correction and special-case substitution are registered into result, and the state goes to DONE.
- DONE: done=result_write=1 for exactly one cycle, then IDLE on the next edge.
- start in CALC or DONE is ignored; no queueing. Operand/rd_in changes after E0 have no effect.
- Writes to x0 are still strobed; the register file discards them.

## Timing
- Reset values: busy=0, done=0, result_write=0, result=0, rd_out=0, state=IDLE, counter=0.
- Latency:
  - Start accepted at E0; iterations at E1..E32.
  - done high during the cycle after E32 (33 cycles after acceptance).
  - Back in IDLE after E33.
  - Earliest next acceptance is E33 if start is high during DONE? No: start is ignored in DONE. Earliest next acceptance is E34.
- Throughput: one operation per 34 cycles.
- result/rd_out are stable for the whole DONE cycle, so the register file's falling-edge write samples settled values.
- Reset asserted mid-operation aborts immediately: outputs return to reset values asynchronously and no write strobe is produced. Release takes effect at the next rising edge with state IDLE.
- Reset asserted during DONE suppresses the remainder of the strobe.
- All ops have identical latency, including special cases.

## Test plan
- MUL 7 × -3 (0x0000_0007, 0xFFFF_FFFD), rd_in=5 -> done 33 cycles after acceptance, result=0xFFFF_FFEB, rd_out=5, result_write high exactly one cycle.
- MULH/MULHSU/MULHU with rs1=0xFFFF_FFFF, rs2=0xFFFF_FFFF -> 0x0000_0000, 0xFFFF_FFFF, 0xFFFF_FFFE respectively.
- DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero with rs1=0x1234_5678: DIV -> 0xFFFF_FFFF, REMU -> 0x1234_5678. Overflow (0x8000_0000 / 0xFFFF_FFFF): DIV -> 0x8000_0000, REM -> 0. All complete in 33 cycles.
- start held high continuously with operands changing each cycle -> exactly one result per 34 cycles, each matching the operands present at its acceptance edge; busy never drops during CALC.
- Reset pulsed at iteration 15 of a DIVU -> busy/done/result/rd_out go to 0 without waiting for a clock; no result_write. A new MUL 3×4 after release returns 12.
